// File: rtl/pipe_collision.sv
// Pipe obstacle scroller and bird collision checker: walks one pipe across the
// playfield, draws gap rows from an LFSR, and tracks score and game-over.
module pipe_collision #(
  parameter int         NUM_COLS     = 16,
  parameter int         BIRD_COL     = 3,
  parameter int         GAP_H        = 4,
  parameter int         GAP_MIN      = 2,
  parameter int         FLOOR_ROW    = 14,
  parameter int         SCROLL_TICKS = 500,
  parameter logic [7:0] LFSR_SEED    = 8'hA5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic signed [31:0] bird_pos,
  output logic               gameover,
  output logic [3:0]         pipe_col,
  output logic [3:0]         gap_top,
  output logic [7:0]         score,
  output logic               running
);

  localparam int TICK_W = (SCROLL_TICKS > 1) ? $clog2(SCROLL_TICKS) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SCROLL_TICKS - 1);
  localparam logic [3:0] COL_LAST  = 4'(NUM_COLS - 1);
  localparam logic [3:0] COL_BIRD  = 4'(BIRD_COL);
  localparam logic [3:0] GAP_BASE  = 4'(GAP_MIN);
  localparam logic [3:0] GAP_RESET = GAP_BASE + {1'b0, LFSR_SEED[2:0]};
  localparam logic signed [31:0] FLOOR_S    = 32'(FLOOR_ROW);
  localparam logic signed [31:0] GAP_SPAN_S = 32'(GAP_H - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_OVER = 2'd2
  } state_e;

  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  state_e              state_q, state_d;
  logic [TICK_W-1:0]   tick_q, tick_d;
  logic [3:0]          pipe_col_q, pipe_col_d;
  logic [3:0]          gap_top_q, gap_top_d;
  logic [7:0]          lfsr_q, lfsr_d;
  logic [7:0]          score_q, score_d;
  logic                gameover_q, gameover_d;
  logic                running_q, running_d;

  logic signed [31:0]  gap_lo_s, gap_hi_s;
  logic                out_of_field_s, outside_gap_s, collision_s;

  // Collision check against the live bird row; gap bounds are zero-extended.
  always_comb begin
    gap_lo_s       = signed'({28'd0, gap_top_q});
    gap_hi_s       = gap_lo_s + GAP_SPAN_S;
    out_of_field_s = (bird_pos < 32'sd0) || (bird_pos >= FLOOR_S);
    outside_gap_s  = (bird_pos < gap_lo_s) || (bird_pos > gap_hi_s);
    collision_s    = out_of_field_s || ((pipe_col_q == COL_BIRD) && outside_gap_s);
  end

  // Next-state logic for the game FSM, scroll timer, pipe, LFSR and score.
  always_comb begin
    state_d    = state_q;
    tick_d     = tick_q;
    pipe_col_d = pipe_col_q;
    gap_top_d  = gap_top_q;
    lfsr_d     = lfsr_q;
    score_d    = score_q;
    gameover_d = gameover_q;
    running_d  = running_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_RUN;
          running_d = 1'b1;
        end else begin
          running_d = 1'b0;
        end
      end
      ST_RUN: begin
        // A crash freezes everything, even on a step cycle.
        if (collision_s) begin
          state_d    = ST_OVER;
          gameover_d = 1'b1;
          running_d  = 1'b0;
        end else if (tick_q == TICK_LAST) begin
          tick_d = '0;
          if ((pipe_col_q == COL_BIRD) && (score_q != 8'hFF)) begin
            score_d = score_q + 8'd1;
          end else begin
            score_d = score_q;
          end
          if (pipe_col_q == 4'd0) begin
            pipe_col_d = COL_LAST;
            lfsr_d     = lfsr_next(lfsr_q);
            gap_top_d  = GAP_BASE + {1'b0, lfsr_d[2:0]};
          end else begin
            pipe_col_d = pipe_col_q - 4'd1;
          end
        end else begin
          tick_d = tick_q + TICK_W'(1);
        end
      end
      ST_OVER: begin
        gameover_d = 1'b1;
        running_d  = 1'b0;
      end
      default: begin
        state_d   = ST_IDLE;
        running_d = 1'b0;
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      tick_q     <= '0;
      pipe_col_q <= COL_LAST;
      gap_top_q  <= GAP_RESET;
      lfsr_q     <= LFSR_SEED;
      score_q    <= 8'd0;
      gameover_q <= 1'b0;
      running_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_q     <= tick_d;
      pipe_col_q <= pipe_col_d;
      gap_top_q  <= gap_top_d;
      lfsr_q     <= lfsr_d;
      score_q    <= score_d;
      gameover_q <= gameover_d;
      running_q  <= running_d;
    end
  end

  assign gameover = gameover_q;
  assign pipe_col = pipe_col_q;
  assign gap_top  = gap_top_q;
  assign score    = score_q;
  assign running  = running_q;

endmodule

// File: doc/pipe_collision.md
Name: pipe_collision

Overview:
Downstream consumer of the bird row position. Scrolls a single pipe obstacle across the playfield grid and draws each new gap row from an LFSR. Compares the bird row against the pipe each cycle, producing the registered gameover flag (fed back to the bird stage) and the score count. Pipe column and gap outputs also drive the display stage.

Parameters:
NUM_COLS, 16, playfield width in columns; pipe spawns at NUM_COLS-1
BIRD_COL, 3, fixed column occupied by the bird
GAP_H, 4, gap height in rows
GAP_MIN, 2, lowest gap_top value; GAP_MIN+7+GAP_H-1 must be <= FLOOR_ROW
FLOOR_ROW, 14, bird row at or beyond which the bird has crashed
SCROLL_TICKS, 500, clk cycles per one-column pipe step
LFSR_SEED, 8'hA5, LFSR reset value; must be nonzero

Ports:
clk  input  1  clock
rst  input  1  synchronous, active-high reset
start  input  1  level; leaves IDLE when high
bird_pos  input  32  signed bird row (0 = top) from the bird stage
gameover  output  1  registered crash flag; held high until rst
pipe_col  output  4  current pipe column
gap_top  output  4  top row of the pipe gap; gap spans gap_top..gap_top+GAP_H-1
score  output  8  pipes cleared, saturating at 255
running  output  1  high while in state RUN

Behaviour:
- Reset values: state IDLE; gameover 0; score 0; pipe_col NUM_COLS-1; lfsr LFSR_SEED; gap_top GAP_MIN+LFSR_SEED[2:0] (7 at defaults); tick 0; running 0.
- rst wins over all other inputs in every state, including mid-RUN and OVER.
- States:
  - IDLE: all outputs held. start=1 moves to RUN on the next edge; tick stays 0.
  - RUN: running=1. tick counts 0..SCROLL_TICKS-1. "Step" means the cycle where tick==SCROLL_TICKS-1; on that edge tick returns to 0.
  - OVER: gameover=1; pipe_col, gap_top, score and lfsr frozen; start ignored. Exit only via rst.
- On a step in RUN:
  - pipe_col > 0: pipe_col decrements.
  - pipe_col == 0: pipe_col becomes NUM_COLS-1 (respawn); lfsr advances once; gap_top becomes GAP_MIN + new lfsr[2:0].
- LFSR: 8-bit Fibonacci, lfsr <= {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}. It advances only on respawn, which keeps the sequence deterministic.
- Collision: evaluated combinationally every RUN cycle from the current bird_pos, pipe_col and gap_top. A collision exists if either condition holds:
  - (a) bird_pos < 0 or bird_pos >= FLOOR_ROW;
  - (b) pipe_col == BIRD_COL and (bird_pos < gap_top or bird_pos > gap_top+GAP_H-1).
  - On collision the state moves to OVER and gameover rises on the same edge (1-cycle latency from the sampled bird_pos).
  - A colliding cycle performs no pipe step and no score increment; collision wins over a simultaneous step.
- Score: increments on a step with pipe_col == BIRD_COL and no collision (the pipe leaves the bird column cleared). It saturates at 255 and never wraps.
- Comparisons treat bird_pos as a signed 32-bit value; gap bounds are zero-extended.
- Bird rows 0..FLOOR_ROW-1 are safe whenever pipe_col != BIRD_COL.

Test Plan:
1. Reset, then hold start=0 for 20 cycles -> gameover=0, score=0, pipe_col=15, gap_top=7, running=0 throughout.
2. SCROLL_TICKS=4, start=1 for one cycle, bird_pos=8 held -> running=1; pipe_col reaches 14 four cycles later; pipe_col=3 after 48 cycles in RUN; on leaving column 3, score=1 and pipe_col=2; gameover stays 0.
3. Same setup with bird_pos=5 while pipe_col==3 -> gameover=1 on the next edge; pipe_col stays 3, score stays 0, running=0; then toggle start and bird_pos=8 -> no change.
4. In RUN with pipe_col=10, drive bird_pos=14 (also separately bird_pos=-1) -> gameover=1 one edge later.
5. Run with bird_pos=8 until the first respawn -> pipe_col 0→15, lfsr 0xA5→0x4A, gap_top=4. Then drive bird_pos=5 through column 3 -> no collision, score increments.
6. Assert rst during RUN (pipe_col=6, score=1) and again in OVER -> all reset values on the next edge. Force score=254 and clear two pipes -> score reads 255 and stays 255.
